topk_sorted_drain: RTL
======================

// Module: topk_sorted_drain
// PURPOSE
//  Collects a valid/ready stream of unsigned words and keeps the K largest, sorted in a register array.
//  On a drain request it streams the kept values out largest-first over a valid/ready port, then clears.
//  Readout companion to the streaming largest/second-largest trackers; feeds rank-ordered consumers.
// PARAMETERS
//  DATA_WIDTH  32  width of din/dout, unsigned
//  K           4   number of largest values kept; legal K>=2
// PORTS
//  clk        in   1                clock, all logic on posedge
//  resetn     in   1                reset, synchronous, active-low
//  in_valid   in   1                din valid
//  in_ready   out  1                block accepts din this cycle
//  din        in   DATA_WIDTH       input sample
//  drain      in   1                request readout (sampled, level, one-cycle effect)
//  out_valid  out  1                dout valid
//  out_ready  in   1                consumer accepts dout
//  dout       out  DATA_WIDTH       current ranked value
//  out_last   out  1                dout is final value of this drain
//  count      out  $clog2(K+1)      occupied slots, saturates at K
// BEHAVIOUR
//  - Reset (resetn=0 at posedge): state=COLLECT, all slots empty, count=0; in_ready=0, out_valid=0, dout=0, out_last=0 while in reset.
//  - States: COLLECT (in_ready=1, out_valid=0) and DRAIN (in_ready=0, out_valid=1).
//  - COLLECT, in_valid&in_ready: din inserted into slot array kept descending (slot0 = largest).
//    Unsigned compare; tie: new value goes after existing equal values.
//    Array full and din <= slot[K-1]: din dropped, array unchanged. Otherwise slot[K-1] is evicted when full.
//    Only occupied slots participate in the compare; count increments until K.
//    Latency: a value accepted at edge N is in the array and reflected in count after edge N.
//  - COLLECT, drain=1: count==0 -> ignored, stay COLLECT. Otherwise -> DRAIN at the next edge, idx=0.
//    Same-cycle in_valid & drain: the sample is accepted first and is included in the drain.
//  - DRAIN: dout=slot[idx], out_last=(idx==count-1).
//    out_valid&out_ready: idx++. On the handshake with out_last=1: clear all slots, count=0, -> COLLECT next cycle.
//    out_ready=0: dout/out_last held stable. drain is ignored in DRAIN; din is not accepted (in_ready=0).
//  - Throughput: one output per cycle with out_ready=1; drain of n values takes n cycles, then 1 cycle back to COLLECT.
//  - resetn=0 mid-DRAIN: output aborted immediately, array cleared, no partial resume.
//  - dout is 0 in COLLECT.
// STRUCTURE
//  - Package topk_pkg: state enum {COLLECT, DRAIN}; helper function for the count width ($clog2(K+1)).
//  - Sub-module topk_slot (one per rank): holds value+occupied bit.
//    Compares din against its own value and the slot above; selects keep / take din / take upper-neighbour value.
//    Generate-instantiated K times.
//  - Top level: FSM, drain index counter, count register, output mux.
// TESTING
//  1 Reset, then push 7,3,9 (K=4), drain, out_ready=1 -> dout 9,7,3 on consecutive cycles, out_last on 3, count 0 after.
//  2 Push 5,1,8,2,6,4 (K=4) -> count=4, drain yields 8,6,5,4; 1 and 2 dropped/evicted.
//  3 Ties: push 5,5,5 -> drain yields 5,5,5, out_last on third. Full array of 9s, push 9 -> dropped, array unchanged.
//  4 Drain with count=0 -> no out_valid, in_ready stays 1.
//    Same-cycle in_valid(din=10)&drain with {4} stored -> drain yields 10,4.
//  5 Backpressure: out_ready low 3 cycles mid-drain -> dout and out_last stable.
//    in_ready=0 throughout DRAIN; din ignored.
//  6 resetn=0 during DRAIN after 1 output -> out_valid=0 next cycle, count=0; a new push of 2 then drain yields only 2.

Source files
------------

// File: rtl/topk_pkg.sv
// Shared types for the top-K sorted drain block.
// Holds the FSM state type and the count-width helper.
package topk_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_t;

    function automatic int cnt_w(input int k);
        return $clog2(k + 1);
    endfunction

endpackage

// File: rtl/topk_sorted_drain_if.sv
// Ingest, drain-request and ranked-output signals of topk_sorted_drain.
// master = producer/consumer side, slave = the block.
interface topk_sorted_drain_if
    import topk_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int K          = 4
);
    localparam int CW = cnt_w(K);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] din;
    logic                  drain;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] dout;
    logic                  out_last;
    logic [CW-1:0]         count;

    modport master (
        output in_valid, din, drain, out_ready,
        input  in_ready, out_valid, dout, out_last, count
    );

    modport slave (
        input  in_valid, din, drain, out_ready,
        output in_ready, out_valid, dout, out_last, count
    );

endinterface

// File: rtl/topk_slot.sv
// One rank of the sorted array: value plus occupied flag.
// Keeps, takes din, or shifts down the neighbour above.
module topk_slot #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_resetn,
    input  logic                  i_clr,
    input  logic                  i_ins,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic [DATA_WIDTH-1:0] i_up_val,
    input  logic                  i_up_occ,
    input  logic                  i_up_gt,
    output logic [DATA_WIDTH-1:0] o_val,
    output logic                  o_occ,
    output logic                  o_gt
);

    logic [DATA_WIDTH-1:0] r_val;
    logic                  r_occ;

    // Strict compare puts a new value after existing equal ones.
    assign o_gt  = !r_occ || (i_din > r_val);
    assign o_val = r_val;
    assign o_occ = r_occ;

    always_ff @(posedge i_clk) begin
        if (!i_resetn || i_clr) begin
            r_val <= '0;
            r_occ <= 1'b0;
        end else if (i_ins && i_up_gt) begin
            r_val <= i_up_val;
            r_occ <= i_up_occ;
        end else if (i_ins && o_gt) begin
            r_val <= i_din;
            r_occ <= 1'b1;
        end
    end

endmodule

// File: rtl/topk_sorted_drain.sv
// Keeps the K largest input words sorted; on drain streams them
// out largest-first over a valid/ready port, then clears.
module topk_sorted_drain
    import topk_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int K          = 4
) (
    input logic                clk,
    input logic                resetn,
    topk_sorted_drain_if.slave bus
);

    localparam int CW = cnt_w(K);

    state_t                r_state;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         r_idx;
    logic [DATA_WIDTH-1:0] w_val [K];
    logic [K-1:0]          w_occ;
    logic [K-1:0]          w_gt;
    logic                  w_acc;
    logic                  w_ins;
    logic                  w_hs;
    logic                  w_last;
    logic                  w_clr;
    logic                  w_go;
    logic [DATA_WIDTH-1:0] w_dout;

    assign bus.in_ready  = resetn && (r_state == COLLECT);
    assign bus.out_valid = resetn && (r_state == DRAIN);
    assign bus.out_last  = bus.out_valid && w_last;
    assign bus.dout      = w_dout;
    assign bus.count     = r_count;

    assign w_acc  = bus.in_valid && bus.in_ready;
    // The gt flags are monotone, so the last rank decides drop vs insert.
    assign w_ins  = w_acc && w_gt[K-1];
    assign w_last = (r_idx == r_count - CW'(1));
    assign w_hs   = bus.out_valid && bus.out_ready;
    assign w_clr  = w_hs && w_last;
    assign w_go   = bus.drain && bus.in_ready
                 && ((r_count != '0) || w_acc);

    for (genvar g = 0; g < K; g++) begin : g_slot
        if (g == 0) begin : g_head
            topk_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
                .i_clk    (clk),
                .i_resetn (resetn),
                .i_clr    (w_clr),
                .i_ins    (w_ins),
                .i_din    (bus.din),
                .i_up_val ('0),
                .i_up_occ (1'b0),
                .i_up_gt  (1'b0),
                .o_val    (w_val[g]),
                .o_occ    (w_occ[g]),
                .o_gt     (w_gt[g])
            );
        end else begin : g_rest
            topk_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
                .i_clk    (clk),
                .i_resetn (resetn),
                .i_clr    (w_clr),
                .i_ins    (w_ins),
                .i_din    (bus.din),
                .i_up_val (w_val[g-1]),
                .i_up_occ (w_occ[g-1]),
                .i_up_gt  (w_gt[g-1]),
                .o_val    (w_val[g]),
                .o_occ    (w_occ[g]),
                .o_gt     (w_gt[g])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= COLLECT;
        end else begin
            unique case (r_state)
                COLLECT: if (w_go)  r_state <= DRAIN;
                DRAIN:   if (w_clr) r_state <= COLLECT;
                default:            r_state <= COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || w_clr) begin
            r_count <= '0;
        end else if (w_ins && !w_occ[K-1]) begin
            r_count <= r_count + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || w_go || w_clr) begin
            r_idx <= '0;
        end else if (w_hs) begin
            r_idx <= r_idx + CW'(1);
        end
    end

    always_comb begin
        w_dout = '0;
        if (bus.out_valid) begin
            for (int i = 0; i < K; i++) begin
                if (r_idx == CW'(i)) w_dout = w_val[i];
            end
        end
    end

endmodule
